glitch_seq: RTL and testbench

GLITCH_SEQ -- requirements
Module: glitch_seq

---
 rtl/glitch_pkg.sv | 25 ++
 rtl/trig_sync.sv | 43 ++++
 rtl/glitch_seq.sv | 175 +++++++++++++++++
 tb/tb_glitch_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
`default_nettype none
// ============================================================================
// glitch_pkg : sequencer state encoding, edge-select codes, default sizes
// Rev 1.0
// ============================================================================
package glitch_pkg;

   localparam int DEF_CNT_W       = 32;
   localparam int DEF_NP_W        = 8;
   localparam int DEF_SYNC_STAGES = 2;

   localparam logic EDGE_RISE = 1'b0;
   localparam logic EDGE_FALL = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_DELAY = 3'd2,
      S_PULSE = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_e;

endpackage
`default_nettype wire

// File: rtl/trig_sync.sv
`default_nettype none
// ============================================================================
// trig_sync : trigger synchroniser with selectable rising/falling edge pulse
// Rev 1.0
// ============================================================================
module trig_sync
   import glitch_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_trigger,
   input  logic i_edge_sel,
   output logic o_edge
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   w_cur;

   assign w_cur = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_trigger};
      prev_d = w_cur;
   end

   // Clearing prev together with the chain keeps the first cycle after reset edge-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign o_edge = (i_edge_sel == EDGE_FALL) ? (prev_q & ~w_cur) : (~prev_q & w_cur);

endmodule
`default_nettype wire

// File: rtl/glitch_seq.sv
`default_nettype none
// ============================================================================
// glitch_seq : armed, trigger-delayed burst generator of timed glitch pulses
// Rev 1.0
// ============================================================================
module glitch_seq
   import glitch_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int NP_W        = DEF_NP_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trigger,
   input  logic             trig_edge,
   input  logic             arm,
   input  logic             abort,
   input  logic [CNT_W-1:0] delay,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] gap,
   input  logic [NP_W-1:0]  count,
   output logic             glitch,
   output logic             armed,
   output logic             delay_ind,
   output logic             done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NP_W-1:0]  left_q, left_d;
   logic [CNT_W-1:0] cfg_delay_q, cfg_delay_d;
   logic [CNT_W-1:0] cfg_width_q, cfg_width_d;
   logic [CNT_W-1:0] cfg_gap_q, cfg_gap_d;
   logic [NP_W-1:0]  cfg_count_q, cfg_count_d;
   logic             cfg_edge_q, cfg_edge_d;
   logic             glitch_q, glitch_d;
   logic             armed_q, armed_d;
   logic             delay_ind_q, delay_ind_d;
   logic             done_q, done_d;

   logic             w_edge;
   logic [CNT_W-1:0] w_width_m1;
   logic [CNT_W-1:0] w_gap_m1;

   trig_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_trig_sync (
      .clk        (clk),
      .rst        (rst),
      .i_trigger  (trigger),
      .i_edge_sel (cfg_edge_q),
      .o_edge     (w_edge)
   );

   // Zero width/gap behave as one cycle; counters hold "cycles remaining minus one".
   assign w_width_m1 = (cfg_width_q == '0) ? '0 : cfg_width_q - CNT_W'(1);
   assign w_gap_m1   = (cfg_gap_q   == '0) ? '0 : cfg_gap_q   - CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      left_d      = left_q;
      cfg_delay_d = cfg_delay_q;
      cfg_width_d = cfg_width_q;
      cfg_gap_d   = cfg_gap_q;
      cfg_count_d = cfg_count_q;
      cfg_edge_d  = cfg_edge_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm && !abort) begin
               cfg_delay_d = delay;
               cfg_width_d = width;
               cfg_gap_d   = gap;
               cfg_count_d = count;
               cfg_edge_d  = trig_edge;
               state_d     = S_ARMED;
            end
         end
         S_ARMED: begin
            if (w_edge) begin
               if (cfg_count_q == '0) begin
                  state_d = S_DONE;
               end else if (cfg_delay_q == '0) begin
                  state_d = S_PULSE;
                  cnt_d   = w_width_m1;
                  left_d  = cfg_count_q - NP_W'(1);
               end else begin
                  state_d = S_DELAY;
                  cnt_d   = cfg_delay_q - CNT_W'(1);
               end
            end
         end
         S_DELAY: begin
            if (cnt_q == '0) begin
               state_d = S_PULSE;
               cnt_d   = w_width_m1;
               left_d  = cfg_count_q - NP_W'(1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_PULSE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (left_q == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_GAP;
               cnt_d   = w_gap_m1;
               left_d  = left_q - NP_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               state_d = S_PULSE;
               cnt_d   = w_width_m1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         left_d  = '0;
      end

      // Indicators are decoded from the next state so they register in step with it.
      glitch_d    = (state_d == S_PULSE);
      armed_d     = (state_d == S_ARMED);
      delay_ind_d = (state_d == S_DELAY) || (state_d == S_PULSE) || (state_d == S_GAP);
      done_d      = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         left_q      <= '0;
         cfg_delay_q <= '0;
         cfg_width_q <= '0;
         cfg_gap_q   <= '0;
         cfg_count_q <= '0;
         cfg_edge_q  <= EDGE_RISE;
         glitch_q    <= 1'b0;
         armed_q     <= 1'b0;
         delay_ind_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         left_q      <= left_d;
         cfg_delay_q <= cfg_delay_d;
         cfg_width_q <= cfg_width_d;
         cfg_gap_q   <= cfg_gap_d;
         cfg_count_q <= cfg_count_d;
         cfg_edge_q  <= cfg_edge_d;
         glitch_q    <= glitch_d;
         armed_q     <= armed_d;
         delay_ind_q <= delay_ind_d;
         done_q      <= done_d;
      end
   end

   assign glitch    = glitch_q;
   assign armed     = armed_q;
   assign delay_ind = delay_ind_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_glitch_seq.sv
`default_nettype none
// ============================================================================
// tb_glitch_seq : directed vector table plus hand-built corner sequences
// Rev 1.0
// ============================================================================
module tb_glitch_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger;
   logic        trig_edge;
   logic        arm;
   logic        abort;
   logic [31:0] delay;
   logic [31:0] width;
   logic [31:0] gap;
   logic [7:0]  count;
   logic        glitch;
   logic        armed;
   logic        delay_ind;
   logic        done;
   logic [3:0]  outs;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] delay;
      logic [31:0] width;
      logic [31:0] gap;
      logic [7:0]  count;
      logic        edge_fall;
      int          exp_first;  // t of first glitch high, t=0 is the detect cycle
      int          exp_done;   // t at which done first reads high
   } vec_t;

   vec_t vecs[6];

   glitch_seq dut (
      .clk       (clk),
      .rst       (rst),
      .trigger   (trigger),
      .trig_edge (trig_edge),
      .arm       (arm),
      .abort     (abort),
      .delay     (delay),
      .width     (width),
      .gap       (gap),
      .count     (count),
      .glitch    (glitch),
      .armed     (armed),
      .delay_ind (delay_ind),
      .done      (done)
   );

   always #5 clk = ~clk;

   assign outs = {glitch, armed, delay_ind, done};

   task automatic check(input string name, input int t, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0d: got {glitch,armed,delay_ind,done}=%b expected %b", name, t, act, exp);
      end
   endtask

   // Expected {glitch,armed,delay_ind,done} at offset t from the detect cycle.
   function automatic logic [3:0] model(input int t, input int first, input int wm, input int gm,
                                        input int done_t);
      logic g, a, di, dn;
      g = 1'b0; a = 1'b0; di = 1'b0; dn = 1'b0;
      if (t <= 0) a = 1'b1;
      else if (t >= done_t) dn = 1'b1;
      else begin
         di = 1'b1;
         if (t >= first) g = (((t - first) % (wm + gm)) < wm);
      end
      return {g, a, di, dn};
   endfunction

   task automatic idle_low_trigger();
      trigger = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_arm(input logic [31:0] d, input logic [31:0] w, input logic [31:0] g,
                         input logic [7:0] c, input logic e);
      delay = d; width = w; gap = g; count = c; trig_edge = e; arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      // Scramble the config bus; the latched copy must be the one used.
      delay = 32'd3; width = 32'd7; gap = 32'd9; count = 8'd5; trig_edge = ~e;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int wm, gm;
      wm = (v.width == 0) ? 1 : int'(v.width);
      gm = (v.gap == 0) ? 1 : int'(v.gap);
      idle_low_trigger();
      do_arm(v.delay, v.width, v.gap, v.count, v.edge_fall);
      check({name, "_armed"}, -2, outs, 4'b0100);
      if (v.edge_fall) begin
         trigger = 1'b1;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check({name, "_rise_ignored"}, i, outs, 4'b0100);
         end
         trigger = 1'b0;
      end else begin
         trigger = 1'b1;
      end
      for (int i = 1; i <= v.exp_done + 2; i++) begin
         @(negedge clk);
         check(name, i - 2, outs, model(i - 2, v.exp_first, wm, gm, v.exp_done));
      end
   endtask

   initial begin
      vecs[0] = '{32'd10, 32'd3, 32'd2, 8'd1, 1'b0, 11, 14};
      vecs[1] = '{32'd0,  32'd1, 32'd0, 8'd4, 1'b0, 1,  8};
      vecs[2] = '{32'd2,  32'd0, 32'd5, 8'd2, 1'b0, 3,  10};
      vecs[3] = '{32'd0,  32'd2, 32'd1, 8'd3, 1'b0, 1,  9};
      vecs[4] = '{32'd5,  32'd3, 32'd3, 8'd0, 1'b0, 0,  1};
      vecs[5] = '{32'd1,  32'd4, 32'd3, 8'd2, 1'b1, 2,  13};

      rst = 1'b1; trigger = 1'b1; trig_edge = 1'b0; arm = 1'b0; abort = 1'b0;
      delay = '0; width = '0; gap = '0; count = '0;
      repeat (3) @(negedge clk);
      check("reset", 0, outs, 4'b0000);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_after_rst", i, outs, 4'b0000);
      end

      foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

      // Abort in the middle of a long pulse, then a later trigger must do nothing.
      idle_low_trigger();
      do_arm(32'd0, 32'd100, 32'd0, 8'd1, 1'b0);
      trigger = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         check("abort_pre", i - 2, outs, model(i - 2, 1, 100, 1, 101));
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_pulse", 0, outs, 4'b0000);
      idle_low_trigger();
      trigger = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("post_abort", i, outs, 4'b0000);
      end

      // Abort together with arm: abort wins, so a trigger afterwards is ignored.
      idle_low_trigger();
      delay = 32'd0; width = 32'd2; gap = 32'd1; count = 8'd1; trig_edge = 1'b0;
      arm = 1'b1; abort = 1'b1;
      @(negedge clk);
      arm = 1'b0; abort = 1'b0;
      check("abort_vs_arm", 0, outs, 4'b0000);
      trigger = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_vs_arm_trig", i, outs, 4'b0000);
      end

      // A second arm while counting the delay must not alter the running sequence.
      idle_low_trigger();
      do_arm(32'd8, 32'd2, 32'd1, 8'd1, 1'b0);
      delay = 32'd0; width = 32'd50; gap = 32'd0; count = 8'd0;
      trigger = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         check("arm_in_delay", i - 2, outs, model(i - 2, 9, 2, 1, 11));
         arm = (i == 5);
      end
      arm = 1'b0;

      // Reset in a gap, asserted together with arm and abort.
      idle_low_trigger();
      do_arm(32'd0, 32'd2, 32'd5, 8'd3, 1'b0);
      trigger = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check("rst_gap_pre", i - 2, outs, model(i - 2, 1, 2, 5, 17));
      end
      rst = 1'b1; arm = 1'b1; abort = 1'b1;
      @(negedge clk);
      rst = 1'b0; arm = 1'b0; abort = 1'b0;
      check("rst_gap", 0, outs, 4'b0000);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("rst_gap_after", i, outs, 4'b0000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
